bs_psum_accumulator: RTL

Downstream stage of the bit-serial MAC unit. It collects the signed 16-bit products the MAC emits at the end of each bit-serial operation and aligns each one for the active reduced-precision level. It accumulates a programmable number of products into a saturating partial sum (dot product). The finished sum is handed to the next stage through a valid/ready handshake.

---
 rtl/bs_psum_accumulator.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bs_psum_accumulator.sv
// ---------------------------------------------------------------------------
// bs_psum_accumulator
//
// Purpose:
//   Downstream stage of the bit-serial MAC. Each signed product emitted by the
//   MAC is aligned for the reduced-precision level latched at start, then
//   added into a saturating partial sum. After a programmable number of
//   products, the finished dot product is offered downstream on a
//   valid/ready handshake.
//
// Ports:
//   clk         in   clock, rising edge
//   rstn        in   asynchronous active-low reset
//   start       in   one-cycle request to begin a dot product (latches config)
//   cfg_len     in   products per dot product, 0 encodes 2^LEN_W
//   prec_level  in   reduced-precision level 0..3 (8/4/2/1 bits processed)
//   prod_valid  in   product-done strobe from the MAC
//   prod_data   in   signed product
//   sum_valid   out  final sum available
//   sum_ready   in   downstream accepts the sum
//   sum_data    out  signed saturated dot product (last delivered value)
//   sum_sat     out  saturation occurred during this dot product
//   busy        out  accumulating or holding a result
//   prod_drop   out  one-cycle pulse: a product arrived while not accumulating
// ---------------------------------------------------------------------------
module bs_psum_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [1:0]        prec_level,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum_data,
  output logic              sum_sat,
  output logic              busy,
  output logic              prod_drop
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [LEN_W:0]   LEN_FULL = {1'b1, {LEN_W{1'b0}}};

  state_t                   state_reg, state_next;
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic [LEN_W:0]           count_reg, count_next;
  logic [LEN_W:0]           len_reg, len_next;
  logic [2:0]               shift_reg, shift_next;
  logic [ACC_W-1:0]         sum_data_reg, sum_data_next;
  logic                     sat_reg, sat_next;
  logic                     drop_reg, drop_next;

  logic [2:0]               shift_sel;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  aligned;
  logic [ACC_W:0]           sum_wide;
  logic                     ovf;
  logic [ACC_W-1:0]         sat_val;
  logic [LEN_W:0]           count_inc;
  logic                     launch;

  // Bits processed at level L is (7>>L)+1, so the product carries
  // 8-bits extra fractional LSBs that must be dropped: 0/4/6/7.
  always_comb begin
    case (prec_level)
      2'd0:    shift_sel = 3'd0;
      2'd1:    shift_sel = 3'd4;
      2'd2:    shift_sel = 3'd6;
      default: shift_sel = 3'd7;
    endcase
  end

  // Sign-extend first, then arithmetic shift: rounds toward minus infinity.
  assign prod_ext = ACC_W'($signed(prod_data));
  assign aligned  = prod_ext >>> shift_reg;

  // One guard bit is enough to detect overflow of a two-operand add:
  // the top two bits of the wide sum disagree exactly when it overflowed.
  assign sum_wide = {acc_reg[ACC_W-1], acc_reg} + {aligned[ACC_W-1], aligned};
  assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign sat_val  = ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX)
                        : sum_wide[ACC_W-1:0];

  assign count_inc = count_reg + 1'b1;

  // A new run may begin from IDLE, or from HOLD in the same cycle the
  // current result is accepted (back-to-back without a bubble).
  assign launch = start && ((state_reg == ST_IDLE) ||
                            ((state_reg == ST_HOLD) && sum_ready));

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    count_next    = count_reg;
    len_next      = len_reg;
    shift_next    = shift_reg;
    sum_data_next = sum_data_reg;
    sat_next      = sat_reg;
    drop_next     = prod_valid && (state_reg != ST_ACCUM);

    case (state_reg)
      ST_ACCUM: begin
        if (prod_valid) begin
          acc_next   = sat_val;
          count_next = count_inc;
          if (ovf) begin
            sat_next = 1'b1;
          end
          if (count_inc == len_reg) begin
            sum_data_next = sat_val;
            state_next    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (sum_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (launch) begin
      state_next = ST_ACCUM;
      acc_next   = '0;
      count_next = '0;
      sat_next   = 1'b0;
      shift_next = shift_sel;
      len_next   = (cfg_len == '0) ? LEN_FULL : {1'b0, cfg_len};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      acc_reg      <= '0;
      count_reg    <= '0;
      len_reg      <= '0;
      shift_reg    <= '0;
      sum_data_reg <= '0;
      sat_reg      <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      count_reg    <= count_next;
      len_reg      <= len_next;
      shift_reg    <= shift_next;
      sum_data_reg <= sum_data_next;
      sat_reg      <= sat_next;
      drop_reg     <= drop_next;
    end
  end

  assign sum_valid = (state_reg == ST_HOLD);
  assign busy      = (state_reg != ST_IDLE);
  assign sum_data  = sum_data_reg;
  assign sum_sat   = sat_reg;
  assign prod_drop = drop_reg;

endmodule
